// File: rtl/mode_dispatch.sv
// mode_dispatch
//   Menu/mode dispatcher. A selector presents a mode code on i_nextState and
//   raises i_load to confirm it. The dispatcher enters that mode, runs it with a
//   one-hot enable, and on a user i_back request leaves the mode. While leaving
//   it re-arms the selector with a low pulse on o_sel_rst_n, then returns to the
//   menu.
//
// Ports
//   i_clk        system clock, all state on rising edge
//   i_rst_n      asynchronous active-low reset
//   i_load       confirm level from selector (async to i_clk)
//   i_nextState  mode code, stable while i_load is high
//   i_back       user exit request level (async to i_clk)
//   o_mode_en    one-hot run enable, bit i high only while mode i runs
//   o_cur_state  mode code of the active / last-entered mode
//   o_in_menu    high while in MENU
//   o_sel_rst_n  registered active-low re-arm pulse to the selector
//   o_err        one-cycle pulse when a load carries an invalid code
module mode_dispatch #(
    parameter int NUM_MODE = 5,
    parameter int RST_CYC  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [2:0] i_nextState,
    input  logic       i_back,
    output logic [7:0] o_mode_en,
    output logic [2:0] o_cur_state,
    output logic       o_in_menu,
    output logic       o_sel_rst_n,
    output logic       o_err
);

    typedef enum logic [1:0] {
        ST_MENU,
        ST_ENTER,
        ST_RUN,
        ST_EXIT
    } state_t;

    // Bits at or above NUM_MODE can never be enabled.
    localparam logic [8:0] MASK9     = (9'd1 << NUM_MODE) - 9'd1;
    localparam logic [7:0] MODE_MASK = MASK9[7:0];

    // Synchronizers (s1, s2) plus the previous synchronized level (d) used by
    // the rising-edge detector. A level that simply stays high never re-fires.
    logic r_load_s1, r_load_s2, r_load_d;
    logic r_back_s1, r_back_s2, r_back_d;
    logic w_load_edge, w_back_edge;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_mode_en;
    logic [2:0] r_cur_state;
    logic       r_in_menu;
    logic       r_sel_rst_n;
    logic       r_err;

    logic       w_valid;
    logic [7:0] w_onehot;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_load_s1 <= 1'b0;
            r_load_s2 <= 1'b0;
            r_load_d  <= 1'b0;
            r_back_s1 <= 1'b0;
            r_back_s2 <= 1'b0;
            r_back_d  <= 1'b0;
        end else begin
            r_load_s1 <= i_load;
            r_load_s2 <= r_load_s1;
            r_load_d  <= r_load_s2;
            r_back_s1 <= i_back;
            r_back_s2 <= r_back_s1;
            r_back_d  <= r_back_s2;
        end
    end

    assign w_load_edge = r_load_s2 & ~r_load_d;
    assign w_back_edge = r_back_s2 & ~r_back_d;

    // i_nextState is held stable by the selector while i_load is high, so it
    // is safe to sample directly once the synchronized load edge arrives.
    assign w_valid  = ({1'b0, i_nextState} < 4'(NUM_MODE));
    assign w_onehot = (8'd1 << r_cur_state) & MODE_MASK;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_MENU;
            r_cnt       <= 4'd0;
            r_mode_en   <= 8'd0;
            r_cur_state <= 3'd0;
            r_in_menu   <= 1'b1;
            r_sel_rst_n <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_MENU: begin
                    // A back edge arriving together with a load is dropped here.
                    if (w_load_edge) begin
                        if (w_valid) begin
                            r_state     <= ST_ENTER;
                            r_cur_state <= i_nextState;
                            r_in_menu   <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ENTER: begin
                    r_state   <= ST_RUN;
                    r_mode_en <= w_onehot;
                end
                ST_RUN: begin
                    if (w_back_edge) begin
                        r_state     <= ST_EXIT;
                        r_mode_en   <= 8'd0;
                        r_sel_rst_n <= 1'b0;
                        // sel_rst_n is already low for this first cycle, so
                        // count the remaining RST_CYC-1.
                        r_cnt       <= 4'(RST_CYC - 1);
                    end
                end
                ST_EXIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_MENU;
                        r_sel_rst_n <= 1'b1;
                        r_in_menu   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state     <= ST_MENU;
                    r_mode_en   <= 8'd0;
                    r_in_menu   <= 1'b1;
                    r_sel_rst_n <= 1'b1;
                end
            endcase
        end
    end

    assign o_mode_en   = r_mode_en;
    assign o_cur_state = r_cur_state;
    assign o_in_menu   = r_in_menu;
    assign o_sel_rst_n = r_sel_rst_n;
    assign o_err       = r_err;

endmodule

// File: doc/mode_dispatch.md
MODE_DISPATCH -- requirements
Module: mode_dispatch

Interface
REQ-001 Parameter NUM_MODE, default 5; number of valid modes (codes 0..NUM_MODE-1), range 1..8.
REQ-002 Parameter RST_CYC, default 4; selector re-arm pulse length in clk cycles, range 1..15.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 load  input  1  confirm level from the mode selector; asynchronous to clk; stays high until the selector is reset.
REQ-006 nextState  input  3  mode code from the selector; stable while load is high.
REQ-007 back  input  1  user exit request; asynchronous to clk; level input.
REQ-008 mode_en  output  8  one-hot run enable; bit i is high only while mode i is running; bits >= NUM_MODE are always 0.
REQ-009 cur_state  output  3  latched mode code of the active or last-entered mode.
REQ-010 in_menu  output  1  high while the FSM is in MENU.
REQ-011 sel_rst_n  output  1  active-low re-arm reset to the selector; registered.
REQ-012 err  output  1  one-cycle pulse when a load carries an invalid code.

Function
REQ-013 load and back SHALL each pass through a 2-flop synchronizer and then a rising-edge detector; the edge pulse lasts 1 cycle.
REQ-014 Synchronized level high with no preceding low (stale level) SHALL NOT produce an edge.
REQ-015 FSM states SHALL be MENU, ENTER, RUN, EXIT; all state outputs are registered.
REQ-016 MENU: load edge with nextState < NUM_MODE -> ENTER, cur_state <= nextState; with nextState >= NUM_MODE -> stay MENU, err pulses 1 cycle, cur_state unchanged.
REQ-017 ENTER: unconditional -> RUN after 1 cycle; mode_en stays 0 in ENTER.
REQ-018 RUN: mode_en = one-hot(cur_state); back edge -> EXIT.
REQ-019 EXIT: mode_en = 0; sel_rst_n = 0 for exactly RST_CYC consecutive cycles, counted by a 4-bit down-counter; when the count expires -> MENU, sel_rst_n returns to 1.
REQ-020 Latency: load rising before clk edge E0 SHALL be edge-detected after E1, reach ENTER at E2, and show mode_en at E3.
REQ-021 load edges outside MENU SHALL be ignored; back edges outside RUN SHALL be ignored.
REQ-022 Simultaneous load edge and back edge in MENU: load is acted on, back is discarded.
REQ-023 in_menu = 1 exactly when state is MENU; mode_en SHALL never have more than one bit set.
REQ-024 The re-arm pulse in EXIT SHALL drop the selector's load, so returning to MENU needs a fresh load edge before any re-entry.

Reset
REQ-025 rst_n low SHALL immediately force state MENU, mode_en=0, cur_state=0, in_menu=1, sel_rst_n=1, err=0, clear the synchronizers and edge detectors, and clear the EXIT counter.
REQ-026 Reset asserted in any state, including mid-EXIT, SHALL abort the operation; after release the block SHALL wait in MENU for a new load edge.

Verification
REQ-027 Reset, then load 0->1 with nextState=2 -> in_menu falls at E2; mode_en=0x04 and cur_state=2 from E3.
REQ-028 In RUN with mode 2, pulse back -> mode_en=0 and sel_rst_n=0 for exactly 4 cycles (default), then in_menu=1; load held high the whole time causes no re-entry.
REQ-029 In MENU, load with nextState=6 -> err high 1 cycle, in_menu stays 1, cur_state unchanged, mode_en=0.
REQ-030 load and back rise in the same cycle in MENU with nextState=0 -> enters mode 0 (mode_en=0x01); back ignored.
REQ-031 Assert rst_n low during EXIT cycle 2 -> all outputs take reset values at once; after release, sel_rst_n=1 and in_menu=1.
REQ-032 Over 1000 random load/back/nextState sequences -> mode_en is always one-hot or zero, and is non-zero only in RUN.
